mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
Multi-cycle control FSM for the MIPS-lite core. It replaces per-instruction combinational control with a sequenced FETCH/DECODE/EXEC/MEM/WB flow. It drives strobes for PC, IR, MDR, GRF and DM, and handshakes with variable-latency instruction and data memories. It covers the instruction set addu, subu, ori, lw, sw, beq, lui, j, jal, jr and nop, and adds a memory-wait watchdog.

Parameters:
WAIT_LIMIT, 255, max cycles spent waiting for im_ready/dm_ready before fault (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
instr  in  32  IR contents (stable after FETCH)
is_eq  in  1  GRF rs==rt comparison from datapath
im_ready  in  1  instruction memory data valid
dm_ready  in  1  data memory access complete
im_req  out  1  instruction fetch request
dm_req  out  1  data memory request
dm_we  out  1  data memory write (qualifies dm_req)
pc_we  out  1  PC write strobe
npc_sel  out  2  0=PC+4, 1=branch (PC+sext(imm)<<2), 2=J target, 3=GPR[rs]
ir_we  out  1  IR write strobe
mdr_we  out  1  MDR write strobe
grf_we  out  1  register file write strobe
alu_op  out  4  0=add, 1=sub, 3=or, 4=lui
alu_src  out  1  0=rt, 1=extended imm
is_sign_ext  out  1  1=sign-extend imm16, 0=zero-extend
reg_dst  out  2  0=rd, 1=rt, 2=$31
which_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC (already PC+4)
retire  out  1  one-cycle pulse on each instruction's final cycle
fault  out  1  sticky watchdog fault

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Reset sets state to FETCH, wait counter to 0 and fault to 0.
- While reset is high, all strobes, requests and retire are forced to 0.
- Decode fields (alu_op, alu_src, is_sign_ext, reg_dst, which_to_reg):
  - Forced to 0 in FETCH and HALT.
  - Otherwise combinational from instr: alu_op=1 for subu, 3 for ori, 4 for lui, else 0.
  - alu_src=1 for ori/lui/lw/sw.
  - is_sign_ext=1 for beq/lw/sw.
  - reg_dst=1 for ori/lui/lw, 2 for jal.
  - which_to_reg=1 for lw, 2 for jal.
- FETCH:
  - im_req=1.
  - On im_ready: ir_we=1, pc_we=1, npc_sel=0, go to DECODE. Otherwise stay.
- DECODE:
  - j: pc_we, npc_sel=2, retire, go to FETCH.
  - jal: grf_we, pc_we, npc_sel=2, retire, go to FETCH.
  - jr: pc_we, npc_sel=3, retire, go to FETCH.
  - nop or any unrecognised encoding: retire, go to FETCH, no writes.
  - All other instructions go to EXEC.
- EXEC:
  - addu/subu/ori/lui go to WB.
  - beq: pc_we=is_eq, npc_sel=1, retire, go to FETCH.
  - lw/sw go to MEM.
- MEM:
  - dm_req=1; dm_we=1 for sw.
  - On dm_ready with sw: retire, go to FETCH.
  - On dm_ready with lw: mdr_we=1, go to WB.
- WB: grf_we=1, retire, go to FETCH.
- Latency: R/I ALU ops take 4 cycles, lw 5, sw 4, beq 3, j/jal/jr/nop 2. Each memory wait cycle adds one.
- Watchdog:
  - 8-bit counter cleared on every state change, incremented each cycle spent in FETCH without im_ready or in MEM without dm_ready.
  - When the counter reaches WAIT_LIMIT and ready is still low, set fault=1 and go to HALT.
  - HALT drives all strobes and requests to 0 and is left only by reset.
- Ready arriving in the same cycle the counter hits WAIT_LIMIT takes priority: normal transition, no fault.
- im_ready outside FETCH and dm_ready outside MEM are ignored.
- Reset during MEM with dm_req high: dm_req drops in the reset cycle and the next state is FETCH. No MDR or GRF write occurs.

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants (ADDU 100001, SUBU 100011, JR 001000, ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111, J 000010, JAL 000011);
  - ALU_OP, NPC_SEL, REG_DST and WTR encodings;
  - the state enum.
- One natural sub-module: mc_decode, the combinational instr-to-class/field decoder, shareable with the single-cycle controller.

Test Plan:
- addu $3,$1,$2 with im_ready high: states 0→1→2→4→0; ir_we and pc_we (npc_sel=0) in cycle 0; grf_we with reg_dst=0, which_to_reg=0 in cycle 3; retire in cycle 3.
- lw with dm_ready delayed 3 cycles: MEM held 4 cycles with dm_req=1, dm_we=0; mdr_we on the ready cycle; WB asserts grf_we, reg_dst=1, which_to_reg=1; 8 cycles total.
- beq with is_eq=1, then beq with is_eq=0: first gives pc_we=1, npc_sel=1 in EXEC; second gives pc_we=0; both retire in cycle 2.
- jal 0x0000100: in DECODE, grf_we=1, reg_dst=2, which_to_reg=2, pc_we=1, npc_sel=2, retire; next state FETCH.
- im_ready held low with WAIT_LIMIT=4: fault=1 after 4 waiting cycles, state HALT, im_req=0; reset then returns to FETCH with fault=0.
- sw with reset asserted during MEM: dm_req=0 in the reset cycle, no retire, FETCH follows with im_req=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-lite encodings: opcodes, functs, control-field codes and controller state.
package mips_pkg;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;

  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnJr   = 6'b001000;

  localparam logic [3:0] AluAdd = 4'd0;
  localparam logic [3:0] AluSub = 4'd1;
  localparam logic [3:0] AluOr  = 4'd3;
  localparam logic [3:0] AluLui = 4'd4;

  localparam logic [1:0] NpcPc4    = 2'd0;
  localparam logic [1:0] NpcBranch = 2'd1;
  localparam logic [1:0] NpcJump   = 2'd2;
  localparam logic [1:0] NpcReg    = 2'd3;

  localparam logic [1:0] DstRd = 2'd0;
  localparam logic [1:0] DstRt = 2'd1;
  localparam logic [1:0] DstRa = 2'd2;

  localparam logic [1:0] WtrAlu = 2'd0;
  localparam logic [1:0] WtrMdr = 2'd1;
  localparam logic [1:0] WtrPc  = 2'd2;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    IcNop, IcAddu, IcSubu, IcOri, IcLui, IcLw, IcSw, IcBeq, IcJ, IcJal, IcJr
  } iclass_e;

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface mc_controller_if;

  logic [31:0] instr;
  logic        is_eq;
  logic        im_ready;
  logic        dm_ready;
  logic        im_req;
  logic        dm_req;
  logic        dm_we;
  logic        pc_we;
  logic [1:0]  npc_sel;
  logic        ir_we;
  logic        mdr_we;
  logic        grf_we;
  logic [3:0]  alu_op;
  logic        alu_src;
  logic        is_sign_ext;
  logic [1:0]  reg_dst;
  logic [1:0]  which_to_reg;
  logic        retire;
  logic        fault;

  modport master (
    input  instr, is_eq, im_ready, dm_ready,
    output im_req, dm_req, dm_we, pc_we, npc_sel, ir_we, mdr_we, grf_we,
           alu_op, alu_src, is_sign_ext, reg_dst, which_to_reg, retire, fault
  );

  modport slave (
    output instr, is_eq, im_ready, dm_ready,
    input  im_req, dm_req, dm_we, pc_we, npc_sel, ir_we, mdr_we, grf_we,
           alu_op, alu_src, is_sign_ext, reg_dst, which_to_reg, retire, fault
  );

endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier and datapath field decoder.
module mc_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output iclass_e     iclass,
  output logic [3:0]  alu_op,
  output logic        alu_src,
  output logic        is_sign_ext,
  output logic [1:0]  reg_dst,
  output logic [1:0]  which_to_reg
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    iclass = IcNop;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAddu:  iclass = IcAddu;
          FnSubu:  iclass = IcSubu;
          FnJr:    iclass = IcJr;
          default: iclass = IcNop;
        endcase
      end
      OpOri:   iclass = IcOri;
      OpLui:   iclass = IcLui;
      OpLw:    iclass = IcLw;
      OpSw:    iclass = IcSw;
      OpBeq:   iclass = IcBeq;
      OpJ:     iclass = IcJ;
      OpJal:   iclass = IcJal;
      default: iclass = IcNop;
    endcase
  end

  always_comb begin
    alu_op       = AluAdd;
    alu_src      = 1'b0;
    is_sign_ext  = 1'b0;
    reg_dst      = DstRd;
    which_to_reg = WtrAlu;
    case (iclass)
      IcSubu: alu_op = AluSub;
      IcOri: begin
        alu_op  = AluOr;
        alu_src = 1'b1;
        reg_dst = DstRt;
      end
      IcLui: begin
        alu_op  = AluLui;
        alu_src = 1'b1;
        reg_dst = DstRt;
      end
      IcLw: begin
        alu_src      = 1'b1;
        is_sign_ext  = 1'b1;
        reg_dst      = DstRt;
        which_to_reg = WtrMdr;
      end
      IcSw: begin
        alu_src     = 1'b1;
        is_sign_ext = 1'b1;
      end
      IcBeq: is_sign_ext = 1'b1;
      IcJal: begin
        reg_dst      = DstRa;
        which_to_reg = WtrPc;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a memory-wait watchdog.
module mc_controller
  import mips_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 255
) (
  input logic             clk,
  input logic             reset,
  mc_controller_if.master bus
);

  localparam logic [7:0] LastWait = 8'(WAIT_LIMIT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;

  iclass_e    iclass;
  logic [3:0] dec_alu_op;
  logic       dec_alu_src, dec_is_sign_ext;
  logic [1:0] dec_reg_dst, dec_which_to_reg;

  logic       im_req, dm_req, dm_we, pc_we, ir_we, mdr_we, grf_we, retire;
  logic [1:0] npc_sel;
  logic       waiting, timeout, field_en;

  mc_decode u_decode (
    .instr        (bus.instr),
    .iclass       (iclass),
    .alu_op       (dec_alu_op),
    .alu_src      (dec_alu_src),
    .is_sign_ext  (dec_is_sign_ext),
    .reg_dst      (dec_reg_dst),
    .which_to_reg (dec_which_to_reg)
  );

  assign waiting = (state_q == StFetch && !bus.im_ready) || (state_q == StMem && !bus.dm_ready);
  // The WAIT_LIMIT-th consecutive waiting cycle is the last one tolerated.
  assign timeout = waiting && (cnt_q == LastWait);

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    im_req  = 1'b0;
    dm_req  = 1'b0;
    dm_we   = 1'b0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    mdr_we  = 1'b0;
    grf_we  = 1'b0;
    retire  = 1'b0;
    npc_sel = NpcPc4;
    case (state_q)
      StFetch: begin
        im_req = 1'b1;
        if (bus.im_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StDecode;
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StDecode: begin
        case (iclass)
          IcJ, IcJal: begin
            grf_we  = (iclass == IcJal);
            pc_we   = 1'b1;
            npc_sel = NpcJump;
            retire  = 1'b1;
            state_d = StFetch;
          end
          IcJr: begin
            pc_we   = 1'b1;
            npc_sel = NpcReg;
            retire  = 1'b1;
            state_d = StFetch;
          end
          IcNop: begin
            retire  = 1'b1;
            state_d = StFetch;
          end
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        case (iclass)
          IcBeq: begin
            pc_we   = bus.is_eq;
            npc_sel = NpcBranch;
            retire  = 1'b1;
            state_d = StFetch;
          end
          IcLw, IcSw: state_d = StMem;
          default:    state_d = StWb;
        endcase
      end
      StMem: begin
        dm_req = 1'b1;
        dm_we  = (iclass == IcSw);
        if (bus.dm_ready) begin
          if (iclass == IcSw) begin
            retire  = 1'b1;
            state_d = StFetch;
          end else begin
            mdr_we  = 1'b1;
            state_d = StWb;
          end
        end else if (timeout) begin
          fault_d = 1'b1;
          state_d = StHalt;
        end
      end
      StWb: begin
        grf_we  = 1'b1;
        retire  = 1'b1;
        state_d = StFetch;
      end
      StHalt:  ;
      default: state_d = StFetch;
    endcase
    if (reset) begin
      im_req = 1'b0;
      dm_req = 1'b0;
      dm_we  = 1'b0;
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mdr_we = 1'b0;
      grf_we = 1'b0;
      retire = 1'b0;
    end
  end

  assign cnt_d = (state_d != state_q) ? 8'd0 : (waiting ? cnt_q + 8'd1 : cnt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      cnt_q   <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign field_en = !(state_q == StFetch || state_q == StHalt);

  assign bus.im_req       = im_req;
  assign bus.dm_req       = dm_req;
  assign bus.dm_we        = dm_we;
  assign bus.pc_we        = pc_we;
  assign bus.npc_sel      = npc_sel;
  assign bus.ir_we        = ir_we;
  assign bus.mdr_we       = mdr_we;
  assign bus.grf_we       = grf_we;
  assign bus.retire       = retire;
  assign bus.fault        = fault_q;
  assign bus.alu_op       = field_en ? dec_alu_op : 4'd0;
  assign bus.alu_src      = field_en & dec_alu_src;
  assign bus.is_sign_ext  = field_en & dec_is_sign_ext;
  assign bus.reg_dst      = field_en ? dec_reg_dst : 2'd0;
  assign bus.which_to_reg = field_en ? dec_which_to_reg : 2'd0;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: per-instruction expected traces built from latency rules.
module tb_mc_controller;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_controller_if bus ();

  mc_controller #(.WAIT_LIMIT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum int {KAddu, KSubu, KOri, KLw, KSw, KBeq, KLui, KJ, KJal, KJr, KNop} kind_e;

  typedef struct packed {
    logic       im_req, dm_req, dm_we, pc_we;
    logic [1:0] npc_sel;
    logic       ir_we, mdr_we, grf_we;
    logic [3:0] alu_op;
    logic       alu_src, is_sign_ext;
    logic [1:0] reg_dst, which_to_reg;
    logic       retire, fault;
  } outs_t;

  // ph: 0 = ready lines are don't-care, 1 = waiting on im_ready, 2 = waiting on dm_ready
  typedef struct {
    outs_t o;
    int    ph;
    bit    rdy;
  } cyc_t;

  cyc_t tr[$];
  int   checks = 0;
  int   errors = 0;

  function automatic outs_t observe();
    outs_t o;
    o.im_req       = bus.im_req;
    o.dm_req       = bus.dm_req;
    o.dm_we        = bus.dm_we;
    o.pc_we        = bus.pc_we;
    o.npc_sel      = bus.npc_sel;
    o.ir_we        = bus.ir_we;
    o.mdr_we       = bus.mdr_we;
    o.grf_we       = bus.grf_we;
    o.alu_op       = bus.alu_op;
    o.alu_src      = bus.alu_src;
    o.is_sign_ext  = bus.is_sign_ext;
    o.reg_dst      = bus.reg_dst;
    o.which_to_reg = bus.which_to_reg;
    o.retire       = bus.retire;
    o.fault        = bus.fault;
    return o;
  endfunction

  function automatic logic [7:0] strobes();
    return {bus.im_req, bus.dm_req, bus.dm_we, bus.pc_we,
            bus.ir_we, bus.mdr_we, bus.grf_we, bus.retire};
  endfunction

  function automatic logic [31:0] make_instr(kind_e k);
    logic [4:0]  rs = 5'($urandom);
    logic [4:0]  rt = 5'($urandom);
    logic [4:0]  rd = 5'($urandom);
    logic [15:0] imm = 16'($urandom);
    logic [25:0] tgt = 26'($urandom);
    case (k)
      KAddu: return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      KSubu: return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      KJr:   return {6'h00, rs, 15'd0, 6'h08};
      KOri:  return {6'h0d, rs, rt, imm};
      KLw:   return {6'h23, rs, rt, imm};
      KSw:   return {6'h2b, rs, rt, imm};
      KBeq:  return {6'h04, rs, rt, imm};
      KLui:  return {6'h0f, 5'd0, rt, imm};
      KJ:    return {6'h02, tgt};
      KJal:  return {6'h03, tgt};
      default: begin
        case ($urandom_range(0, 2))
          0:       return 32'h0;
          1:       return {6'h08, tgt};
          default: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
        endcase
      end
    endcase
  endfunction

  // Datapath fields every instruction presents outside FETCH/HALT.
  function automatic outs_t fields(kind_e k);
    outs_t o = '0;
    case (k)
      KSubu: o.alu_op = 4'd1;
      KOri:  begin o.alu_op = 4'd3; o.alu_src = 1'b1; o.reg_dst = 2'd1; end
      KLui:  begin o.alu_op = 4'd4; o.alu_src = 1'b1; o.reg_dst = 2'd1; end
      KLw:   begin o.alu_src = 1'b1; o.is_sign_ext = 1'b1; o.reg_dst = 2'd1; o.which_to_reg = 2'd1; end
      KSw:   begin o.alu_src = 1'b1; o.is_sign_ext = 1'b1; end
      KBeq:  o.is_sign_ext = 1'b1;
      KJal:  begin o.reg_dst = 2'd2; o.which_to_reg = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic cyc_t mk(outs_t o, int ph, bit rdy);
    cyc_t c;
    c.o = o; c.ph = ph; c.rdy = rdy;
    return c;
  endfunction

  task automatic build(kind_e k, int d_im, int d_dm, bit eq);
    outs_t f = fields(k);
    outs_t o;
    tr.delete();
    for (int i = 0; i < d_im; i++) begin
      o = '0; o.im_req = 1'b1;
      tr.push_back(mk(o, 1, 1'b0));
    end
    o = '0; o.im_req = 1'b1; o.ir_we = 1'b1; o.pc_we = 1'b1;
    tr.push_back(mk(o, 1, 1'b1));
    o = f;
    if (k == KJ || k == KJal || k == KJr || k == KNop) begin
      o.retire = 1'b1;
      if (k != KNop) begin
        o.pc_we   = 1'b1;
        o.npc_sel = (k == KJr) ? 2'd3 : 2'd2;
      end
      o.grf_we = (k == KJal);
      tr.push_back(mk(o, 0, 1'b0));
    end else begin
      tr.push_back(mk(f, 0, 1'b0));
      if (k == KBeq) begin
        o = f; o.pc_we = eq; o.npc_sel = 2'd1; o.retire = 1'b1;
        tr.push_back(mk(o, 0, 1'b0));
      end else begin
        tr.push_back(mk(f, 0, 1'b0));
        if (k == KLw || k == KSw) begin
          for (int i = 0; i <= d_dm; i++) begin
            o = f; o.dm_req = 1'b1; o.dm_we = (k == KSw);
            if (i == d_dm) begin
              o.retire = (k == KSw);
              o.mdr_we = (k == KLw);
            end
            tr.push_back(mk(o, 2, i == d_dm));
          end
        end
        if (k != KSw) begin
          o = f; o.grf_we = 1'b1; o.retire = 1'b1;
          tr.push_back(mk(o, 0, 1'b0));
        end
      end
    end
  endtask

  // Plays the first ncyc entries of tr (all if ncyc < 0); entered and left at posedge+1.
  task automatic run(string name, logic [31:0] ins, bit eq, int ncyc);
    outs_t act, exp;
    bus.instr = ins;
    bus.is_eq = eq;
    for (int c = 0; c < tr.size() && (ncyc < 0 || c < ncyc); c++) begin
      bus.im_ready = (tr[c].ph == 1) ? tr[c].rdy : 1'($urandom);
      bus.dm_ready = (tr[c].ph == 2) ? tr[c].rdy : 1'($urandom);
      @(negedge clk);
      act = observe();
      exp = tr[c].o;
      if (!exp.pc_we) begin
        act.npc_sel = 2'd0;
        exp.npc_sel = 2'd0;
      end
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL %s cyc %0d: got %h want %h", name, c, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.im_ready = 1'b0;
    bus.dm_ready = 1'b0;
    bus.is_eq    = 1'b0;
    bus.instr    = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    outs_t exp;
    do_reset();
    reset        = 1'b1;
    bus.im_ready = 1'b1;
    bus.dm_ready = 1'b1;
    bus.instr    = make_instr(KAddu);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (strobes() !== 8'h00) begin
        errors++;
        $display("FAIL reset_strobes: got %h want 00", strobes());
      end
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.im_ready = 1'b0;
    @(negedge clk);
    exp = '0; exp.im_req = 1'b1;
    checks++;
    if (observe() !== exp) begin
      errors++;
      $display("FAIL reset_fetch: got %h want %h", observe(), exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_addu();
    do_reset();
    build(KAddu, 0, 0, 1'b0);
    run("addu", {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21}, 1'b0, -1);
  endtask

  task automatic test_lw_delay();
    do_reset();
    build(KLw, 0, 3, 1'b0);
    run("lw_delay", make_instr(KLw), 1'b0, -1);
  endtask

  task automatic test_beq();
    logic [31:0] ins;
    do_reset();
    ins = make_instr(KBeq);
    build(KBeq, 0, 0, 1'b1);
    run("beq_taken", ins, 1'b1, -1);
    build(KBeq, 0, 0, 1'b0);
    run("beq_not_taken", ins, 1'b0, -1);
  endtask

  task automatic test_jal();
    do_reset();
    build(KJal, 0, 0, 1'b0);
    run("jal", {6'h03, 26'h0000100}, 1'b0, -1);
  endtask

  task automatic test_wait_boundary();
    do_reset();
    build(KAddu, 3, 0, 1'b0);
    run("fetch_at_limit", make_instr(KAddu), 1'b0, -1);
    build(KSw, 3, 3, 1'b0);
    run("sw_at_limit", make_instr(KSw), 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    kind_e k;
    bit    eq;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      k  = kind_e'($urandom_range(0, 10));
      eq = 1'($urandom);
      build(k, $urandom_range(0, 3), $urandom_range(0, 3), eq);
      run($sformatf("rand%0d_k%0d", n, k), make_instr(k), eq, -1);
    end
  endtask

  task automatic test_reset_in_mem();
    outs_t exp;
    do_reset();
    build(KSw, 0, 3, 1'b0);
    run("sw_pre_mem", make_instr(KSw), 1'b0, 3);
    reset        = 1'b1;
    bus.dm_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (strobes() !== 8'h00) begin
      errors++;
      $display("FAIL reset_in_mem: got %h want 00", strobes());
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.im_ready = 1'b0;
    @(negedge clk);
    exp = '0; exp.im_req = 1'b1;
    checks++;
    if (observe() !== exp) begin
      errors++;
      $display("FAIL after_mem_reset: got %h want %h", observe(), exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_watchdog();
    outs_t exp;
    do_reset();
    bus.instr = make_instr(KAddu);
    for (int c = 0; c < 7; c++) begin
      bus.im_ready = (c < 4) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      exp = '0;
      if (c < 4) exp.im_req = 1'b1;
      else       exp.fault  = 1'b1;
      checks++;
      if (observe() !== exp) begin
        errors++;
        $display("FAIL watchdog cyc %0d: got %h want %h", c, observe(), exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.im_ready = 1'b0;
    @(negedge clk);
    exp = '0; exp.im_req = 1'b1;
    checks++;
    if (observe() !== exp) begin
      errors++;
      $display("FAIL watchdog_clear: got %h want %h", observe(), exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_delay();
    test_beq();
    test_jal();
    test_wait_boundary();
    test_back_to_back();
    test_reset_in_mem();
    test_watchdog();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
